// File: rtl/aes_pkg.sv
// Shared AES parameters, block/key/counter types and the CTR scheduler state encoding.
package aes_pkg;

  localparam int Nb     = 4;
  localparam int Nk     = 4;
  localparam int Nr     = 10;
  localparam int BLK_W  = 32 * Nb;
  localparam int KEY_W  = 32 * Nk;
  localparam int CTR_W  = 64;
  localparam int IV_W   = BLK_W - CTR_W;
  localparam int NBLK_W = 16;

  typedef logic [BLK_W-1:0]  block_t;
  typedef logic [KEY_W-1:0]  key_t;
  typedef logic [CTR_W-1:0]  ctr_t;
  typedef logic [IV_W-1:0]   iv_t;
  typedef logic [NBLK_W-1:0] nblk_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/aes_ctr_sched.sv
// Counter-mode scheduler: issues {iv, ctr} blocks to the AES core one at a time and
// XORs each returned keystream block onto the matching ciphertext block.
module aes_ctr_sched
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IV_W-1:0]   cfg_iv,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic [NBLK_W-1:0] cfg_nblk,
  // Test hook: start the counter at cfg_ctr_init instead of zero; tie low in normal use.
  input  logic              cfg_ctr_load,
  input  logic [CTR_W-1:0]  cfg_ctr_init,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BLK_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_data,
  output logic              core_start,
  output logic [BLK_W-1:0]  core_block,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_ready,
  input  logic [BLK_W-1:0]  core_out,
  output logic              busy,
  output logic              done
);

  sched_state_t state_q, state_d;
  iv_t          iv_q, iv_d;
  key_t         key_q, key_d;
  ctr_t         ctr_q, ctr_d;
  nblk_t        rem_q, rem_d;
  block_t       ks_q, ks_d;
  block_t       ct_q, ct_d;
  logic         ks_have_q, ks_have_d;
  logic         ct_have_q, ct_have_d;
  block_t       out_data_q, out_data_d;
  logic         cfg_ready_q, cfg_ready_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         core_start_q, core_start_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Next-state logic; every output is registered from the next state.
  always_comb begin
    state_d    = state_q;
    iv_d       = iv_q;
    key_d      = key_q;
    ctr_d      = ctr_q;
    rem_d      = rem_q;
    ks_d       = ks_q;
    ct_d       = ct_q;
    ks_have_d  = ks_have_q;
    ct_have_d  = ct_have_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          iv_d      = cfg_iv;
          key_d     = cfg_key;
          rem_d     = cfg_nblk;
          ctr_d     = cfg_ctr_load ? cfg_ctr_init : ctr_t'(1'b0);
          ks_have_d = 1'b0;
          ct_have_d = 1'b0;
          if (cfg_nblk == nblk_t'(1'b0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (in_valid && in_ready_q) begin
          ct_d      = in_data;
          ct_have_d = 1'b1;
        end else begin
          ct_have_d = ct_have_q;
        end
        if (core_ready) begin
          ks_d      = core_out;
          ks_have_d = 1'b1;
        end else begin
          ks_have_d = ks_have_q;
        end
        // Same-cycle arrivals are folded in so the result is ready one cycle later.
        if (ks_have_d && ct_have_d) begin
          out_data_d = ks_d ^ ct_d;
          ks_have_d  = 1'b0;
          ct_have_d  = 1'b0;
          state_d    = OUT;
        end else begin
          state_d = WAIT;
        end
      end

      OUT: begin
        if (out_ready) begin
          ctr_d = ctr_q + ctr_t'(1'b1);
          rem_d = rem_q - nblk_t'(1'b1);
          if (rem_q == nblk_t'(1'b1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = OUT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cfg_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    core_start_d = (state_d == ISSUE);
    out_valid_d  = (state_d == OUT);
    in_ready_d   = (state_d == WAIT) && !ct_have_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      iv_q         <= '0;
      key_q        <= '0;
      ctr_q        <= '0;
      rem_q        <= '0;
      ks_q         <= '0;
      ct_q         <= '0;
      ks_have_q    <= 1'b0;
      ct_have_q    <= 1'b0;
      out_data_q   <= '0;
      cfg_ready_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      iv_q         <= iv_d;
      key_q        <= key_d;
      ctr_q        <= ctr_d;
      rem_q        <= rem_d;
      ks_q         <= ks_d;
      ct_q         <= ct_d;
      ks_have_q    <= ks_have_d;
      ct_have_q    <= ct_have_d;
      out_data_q   <= out_data_d;
      cfg_ready_q  <= cfg_ready_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign core_start = core_start_q;
  assign core_block = {iv_q, ctr_q};
  assign core_key   = key_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
